// File: rtl/pci_target_read_seq_pkg.sv
// Shared definitions for the PCI target read sequencer: the two accepted
// memory-read command codes, the FSM state encoding, and a command check.
package pci_target_read_seq_pkg;

  localparam logic [3:0] CMD_MEM_READ      = 4'b0110;
  localparam logic [3:0] CMD_MEM_READ_MULT = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TURN    = 3'd1,
    S_DATA    = 3'd2,
    S_STOPPED = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  function automatic logic is_mem_read(input logic [3:0] cbe_n);
    return (cbe_n == CMD_MEM_READ) || (cbe_n == CMD_MEM_READ_MULT);
  endfunction

endpackage

// File: rtl/pci_bar_decode.sv
// Combinational BAR hit detection for one memory window.
// Ports:
//   ad_in  - AD bus during the address phase (32 bits)
//   cbe_n  - C/BE# during the address phase (command)
//   hit    - 1 when the command is a memory read and the address lies in the window
module pci_bar_decode
  import pci_target_read_seq_pkg::*;
#(
  parameter logic [31:0] BAR_BASE      = 32'h0000_0000,
  parameter int          BAR_SIZE_LOG2 = 8
) (
  input  logic [31:0] ad_in,
  input  logic [3:0]  cbe_n,
  output logic        hit
);

  // Offset bits inside the window play no part in the decode.
  logic unused_ad_lo;
  assign unused_ad_lo = ^ad_in[BAR_SIZE_LOG2-1:0];

  assign hit = is_mem_read(cbe_n) &&
               (ad_in[31:BAR_SIZE_LOG2] == BAR_BASE[31:BAR_SIZE_LOG2]);

endmodule

// File: rtl/pci_target_read_seq.sv
// PCI target read-data sequencer. Claims memory reads that hit one BAR window
// (fast DEVSEL#), inserts the AD turnaround cycle, then streams words fetched
// from a local read port onto AD with zero wait states. STOP# is raised with
// the last word of the window so the burst never wraps on the bus.
// Ports:
//   clk, rst                 - PCI clock, async active-high reset
//   frame_n, irdy_n          - master control, sampled
//   ad_in, cbe_n             - AD and C/BE# as received
//   ad_out, ad_oe_n          - read data and its AD driver enable (0 = drive)
//   devsel_n, trdy_n, stop_n - target control values
//   s_oe_n                   - shared driver enable for the target controls
//   rd_en, rd_addr, rd_data  - local read port, data valid in the rd_en cycle
module pci_target_read_seq
  import pci_target_read_seq_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter logic [31:0] BAR_BASE      = 32'h0000_0000,
  parameter int          BAR_SIZE_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_n,
  input  logic                     irdy_n,
  input  logic [WIDTH-1:0]         ad_in,
  input  logic [3:0]               cbe_n,
  output logic [WIDTH-1:0]         ad_out,
  output logic                     ad_oe_n,
  output logic                     devsel_n,
  output logic                     trdy_n,
  output logic                     stop_n,
  output logic                     s_oe_n,
  output logic                     rd_en,
  output logic [BAR_SIZE_LOG2-3:0] rd_addr,
  input  logic [WIDTH-1:0]         rd_data
);

  localparam int AW = BAR_SIZE_LOG2 - 2;
  localparam logic [AW-1:0] LAST_WORD = '1;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_nxt;
  logic          frame_q;
  logic          hit;
  logic          addr_phase;

  pci_bar_decode #(
    .BAR_BASE      (BAR_BASE),
    .BAR_SIZE_LOG2 (BAR_SIZE_LOG2)
  ) u_bar_decode (
    .ad_in (ad_in[31:0]),
    .cbe_n (cbe_n),
    .hit   (hit)
  );

  assign addr_phase = frame_q && !frame_n;
  assign addr_nxt   = addr + AW'(1);

  // The read strobe is combinational so the next word is fetched in the same
  // cycle the master completes the current one, giving one word per clock.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = addr;
    case (state)
      S_TURN: rd_en = 1'b1;
      S_DATA: begin
        rd_addr = addr_nxt;
        rd_en   = !irdy_n && !frame_n && stop_n;
      end
      default: ;
    endcase
  end

  // Control outputs are registered with the value belonging to the state
  // being entered, so they change exactly when the state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ad_out   <= '0;
      addr     <= '0;
      frame_q  <= 1'b1;
      ad_oe_n  <= 1'b1;
      s_oe_n   <= 1'b1;
      devsel_n <= 1'b1;
      trdy_n   <= 1'b1;
      stop_n   <= 1'b1;
    end else begin
      frame_q <= frame_n;
      case (state)
        S_IDLE: begin
          if (addr_phase && hit) begin
            state    <= S_TURN;
            addr     <= ad_in[BAR_SIZE_LOG2-1:2];
            s_oe_n   <= 1'b0;
            devsel_n <= 1'b0;
            trdy_n   <= 1'b1;
            stop_n   <= 1'b1;
            ad_oe_n  <= 1'b1;
          end
        end
        S_TURN: begin
          state   <= S_DATA;
          ad_out  <= rd_data;
          ad_oe_n <= 1'b0;
          trdy_n  <= 1'b0;
          stop_n  <= (addr != LAST_WORD);
        end
        S_DATA: begin
          // frame_n high ends the transaction whether or not IRDY# completes
          // the final phase (the latter being a master abandon).
          if (frame_n) begin
            state    <= S_RELEASE;
            ad_oe_n  <= 1'b1;
            devsel_n <= 1'b1;
            trdy_n   <= 1'b1;
            stop_n   <= 1'b1;
          end else if (!irdy_n) begin
            if (!stop_n) begin
              state   <= S_STOPPED;
              ad_oe_n <= 1'b1;
              trdy_n  <= 1'b1;
            end else begin
              ad_out <= rd_data;
              addr   <= addr_nxt;
              stop_n <= (addr_nxt != LAST_WORD);
            end
          end
        end
        S_STOPPED: begin
          if (frame_n) begin
            state    <= S_RELEASE;
            devsel_n <= 1'b1;
            stop_n   <= 1'b1;
          end
        end
        S_RELEASE: begin
          state  <= S_IDLE;
          s_oe_n <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          ad_oe_n  <= 1'b1;
          s_oe_n   <= 1'b1;
          devsel_n <= 1'b1;
          trdy_n   <= 1'b1;
          stop_n   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_target_read_seq.sv
// Directed bench for pci_target_read_seq. The local memory returns
// {16'hCAFE, word index}, so the expected data words are written out literally.
module tb_pci_target_read_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_n;
  logic        irdy_n;
  logic [31:0] ad_in;
  logic [3:0]  cbe_n;
  logic [31:0] ad_out;
  logic        ad_oe_n;
  logic        devsel_n;
  logic        trdy_n;
  logic        stop_n;
  logic        s_oe_n;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rd_data = {16'hCAFE, 10'd0, rd_addr};

  pci_target_read_seq #(
    .WIDTH         (32),
    .BAR_BASE      (32'h0000_0000),
    .BAR_SIZE_LOG2 (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .ad_in    (ad_in),
    .cbe_n    (cbe_n),
    .ad_out   (ad_out),
    .ad_oe_n  (ad_oe_n),
    .devsel_n (devsel_n),
    .trdy_n   (trdy_n),
    .stop_n   (stop_n),
    .s_oe_n   (s_oe_n),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then stop at the
  // falling edge where outputs of that cycle are compared.
  task automatic go(input logic f, input logic i, input logic [31:0] ad, input logic [3:0] cbe);
    @(posedge clk);
    #1;
    frame_n = f;
    irdy_n  = i;
    ad_in   = ad;
    cbe_n   = cbe;
    @(negedge clk);
  endtask

  // devsel, trdy, stop, s_oe, ad_oe packed in that order
  function automatic logic [4:0] ctl();
    return {devsel_n, trdy_n, stop_n, s_oe_n, ad_oe_n};
  endfunction

  initial begin
    rst = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; ad_in = '0; cbe_n = 4'hF;
    #12;
    chk("rst_ctl",    32'(ctl()),  32'h1F);
    chk("rst_ad_out", ad_out,      32'h0);
    chk("rst_rd_en",  32'(rd_en),  32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // idle
    go(1, 1, 32'h0, 4'hF);
    chk("idle_ctl", 32'(ctl()), 32'h1F);

    // single read of word 4
    go(0, 1, 32'h0000_0010, 4'b0110);
    chk("sr_A_ctl", 32'(ctl()), 32'h1F);
    go(1, 0, 32'h0, 4'h0);
    chk("sr_A1_ctl",   32'(ctl()),   32'h0D);   // devsel 0, s_oe 0, ad_oe 1
    chk("sr_A1_rd_en", 32'(rd_en),   32'h1);
    chk("sr_A1_raddr", 32'(rd_addr), 32'd4);
    go(1, 0, 32'h0, 4'h0);
    chk("sr_A2_ctl",   32'(ctl()),   32'h04);   // devsel 0, trdy 0, stop 1, drive
    chk("sr_A2_data",  ad_out,       32'hCAFE_0004);
    chk("sr_A2_rd_en", 32'(rd_en),   32'h0);
    go(1, 1, 32'h0, 4'h0);
    chk("sr_A3_release", 32'(ctl()), 32'h1D);
    go(1, 1, 32'h0, 4'h0);
    chk("sr_A4_idle", 32'(ctl()), 32'h1F);

    // burst of four from word 0 using memory-read-multiple
    go(0, 1, 32'h0000_0000, 4'b1100);
    go(0, 0, 32'h0, 4'h0);
    chk("b4_turn_rd_en", 32'(rd_en),   32'h1);
    chk("b4_turn_raddr", 32'(rd_addr), 32'd0);
    go(0, 0, 32'h0, 4'h0);
    chk("b4_w0", ad_out, 32'hCAFE_0000);
    chk("b4_w0_rd_en", 32'(rd_en), 32'h1);
    chk("b4_w0_ctl", 32'(ctl()), 32'h04);
    go(0, 0, 32'h0, 4'h0);
    chk("b4_w1", ad_out, 32'hCAFE_0001);
    chk("b4_w1_rd_en", 32'(rd_en), 32'h1);
    go(0, 0, 32'h0, 4'h0);
    chk("b4_w2", ad_out, 32'hCAFE_0002);
    chk("b4_w2_raddr", 32'(rd_addr), 32'd3);
    go(1, 0, 32'h0, 4'h0);
    chk("b4_w3", ad_out, 32'hCAFE_0003);
    chk("b4_w3_rd_en", 32'(rd_en), 32'h0);
    go(1, 1, 32'h0, 4'h0);
    chk("b4_release", 32'(ctl()), 32'h1D);
    go(1, 1, 32'h0, 4'h0);

    // IRDY# wait states in the middle of a burst from word 8
    go(0, 1, 32'h0000_0020, 4'b0110);
    go(0, 0, 32'h0, 4'h0);
    go(0, 0, 32'h0, 4'h0);
    chk("iw_w8", ad_out, 32'hCAFE_0008);
    go(0, 1, 32'h0, 4'h0);
    chk("iw_wait1_data",  ad_out,     32'hCAFE_0009);
    chk("iw_wait1_rd_en", 32'(rd_en), 32'h0);
    chk("iw_wait1_ctl",   32'(ctl()), 32'h04);
    go(0, 1, 32'h0, 4'h0);
    chk("iw_wait2_data",  ad_out,     32'hCAFE_0009);
    chk("iw_wait2_rd_en", 32'(rd_en), 32'h0);
    go(0, 0, 32'h0, 4'h0);
    chk("iw_resume_rd_en", 32'(rd_en),   32'h1);
    chk("iw_resume_raddr", 32'(rd_addr), 32'd10);
    go(1, 0, 32'h0, 4'h0);
    chk("iw_w10", ad_out, 32'hCAFE_000A);
    go(1, 1, 32'h0, 4'h0);
    go(1, 1, 32'h0, 4'h0);
    chk("iw_idle", 32'(ctl()), 32'h1F);

    // window end: burst from word 62 gets STOP# with word 63
    go(0, 1, 32'h0000_00F8, 4'b0110);
    go(0, 0, 32'h0, 4'h0);
    go(0, 0, 32'h0, 4'h0);
    chk("we_w62", ad_out, 32'hCAFE_003E);
    chk("we_w62_ctl", 32'(ctl()), 32'h04);
    go(0, 0, 32'h0, 4'h0);
    chk("we_w63", ad_out, 32'hCAFE_003F);
    chk("we_w63_ctl", 32'(ctl()), 32'h00);      // stop 0 with data
    chk("we_w63_rd_en", 32'(rd_en), 32'h0);
    go(0, 1, 32'h0, 4'h0);
    chk("we_stopped1", 32'(ctl()), 32'h09);     // devsel 0, trdy 1, stop 0, ad released
    go(1, 1, 32'h0, 4'h0);
    chk("we_stopped2", 32'(ctl()), 32'h09);
    go(1, 1, 32'h0, 4'h0);
    chk("we_release", 32'(ctl()), 32'h1D);
    go(1, 1, 32'h0, 4'h0);
    chk("we_idle", 32'(ctl()), 32'h1F);

    // miss outside the window and an unsupported command
    go(0, 1, 32'h0000_0100, 4'b0110);
    go(1, 1, 32'h0, 4'h0);
    chk("miss_ctl",   32'(ctl()),  32'h1F);
    chk("miss_rd_en", 32'(rd_en),  32'h0);
    go(1, 1, 32'h0, 4'h0);
    go(0, 1, 32'h0000_0010, 4'b0111);
    go(1, 1, 32'h0, 4'h0);
    chk("cmd_ctl",   32'(ctl()), 32'h1F);
    chk("cmd_rd_en", 32'(rd_en), 32'h0);

    // asynchronous reset while in DATA
    go(1, 1, 32'h0, 4'h0);
    go(0, 1, 32'h0000_0010, 4'b0110);
    go(0, 1, 32'h0, 4'h0);
    go(0, 1, 32'h0, 4'h0);
    chk("ar_in_data", 32'(ctl()), 32'h04);
    #1 rst = 1'b1;
    #1;
    chk("ar_async_ctl", 32'(ctl()), 32'h1F);
    chk("ar_async_ad_out", ad_out, 32'h0);
    @(posedge clk); #1;
    chk("ar_rd_en", 32'(rd_en), 32'h0);
    rst = 1'b0; frame_n = 1'b1; irdy_n = 1'b1;
    go(1, 1, 32'h0, 4'h0);
    chk("ar_idle", 32'(ctl()), 32'h1F);
    go(0, 1, 32'h0000_0014, 4'b0110);
    go(1, 0, 32'h0, 4'h0);
    chk("ar_reclaim_ctl",   32'(ctl()),   32'h0D);
    chk("ar_reclaim_raddr", 32'(rd_addr), 32'd5);
    go(1, 0, 32'h0, 4'h0);
    chk("ar_reclaim_data", ad_out, 32'hCAFE_0005);
    go(1, 1, 32'h0, 4'h0);
    go(1, 1, 32'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
